// File: rtl/alu_exec_pkg.sv
// Shared definitions for the NandGame-style execution unit: FSM encoding,
// instruction field positions and the decoded ALU control bundle.
package alu_exec_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RD   = 2'd1;
    localparam logic [1:0] EXEC = 2'd2;
    localparam logic [1:0] WR   = 2'd3;

    localparam int CI      = 15;
    localparam int SEL_MEM = 12;
    localparam int U       = 10;
    localparam int OP1     = 9;
    localparam int OP0     = 8;
    localparam int ZX      = 7;
    localparam int SW      = 6;
    localparam int DST_A   = 5;
    localparam int DST_D   = 4;
    localparam int DST_MEM = 3;
    localparam int LT      = 2;
    localparam int EQ      = 1;
    localparam int GT      = 0;

    typedef struct packed {
        logic u;
        logic op1;
        logic op0;
        logic zx;
        logic sw;
    } alu_ctrl_t;

endpackage

// File: rtl/alu_exec_if.sv
// Instruction handshake plus data-memory req/ack bus of the execution unit.
// master = execution unit, slave = fetch stage / memory side.
interface alu_exec_if #(parameter int WIDTH = 16);

    logic             instr_valid;
    logic             instr_ready;
    logic [WIDTH-1:0] instr;
    logic             mem_req;
    logic             mem_we;
    logic [WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0] mem_wdata;
    logic [WIDTH-1:0] mem_rdata;
    logic             mem_ack;

    modport master (
        input  instr_valid, instr, mem_rdata, mem_ack,
        output instr_ready, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output instr_valid, instr, mem_rdata, mem_ack,
        input  instr_ready, mem_req, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/alu16_core.sv
// Combinational 16-bit NandGame ALU: optional operand swap, zero-X, then a
// logic unit (and/or/xor/not) or an arithmetic unit (add/inc/sub/dec).
module alu16_core (
    input  logic [15:0] x_i,
    input  logic [15:0] y_i,
    input  logic        u_i,
    input  logic        op1_i,
    input  logic        op0_i,
    input  logic        zx_i,
    input  logic        sw_i,
    output logic [15:0] r_o
);

    logic [15:0] xs;
    logic [15:0] ys;
    logic [15:0] logicR;
    logic [15:0] arithR;

    assign xs = zx_i ? 16'h0000 : (sw_i ? y_i : x_i);
    assign ys = sw_i ? x_i : y_i;

    always_comb begin
        logicR = 16'h0000;
        unique case ({op1_i, op0_i})
            2'b00: logicR = xs & ys;
            2'b01: logicR = xs | ys;
            2'b10: logicR = xs ^ ys;
            2'b11: logicR = ~xs;
            default: logicR = 16'h0000;
        endcase
    end

    // Carry and borrow fall off the top; results wrap modulo 2^16.
    always_comb begin
        arithR = 16'h0000;
        unique case ({op1_i, op0_i})
            2'b00: arithR = xs + ys;
            2'b01: arithR = xs + 16'd1;
            2'b10: arithR = xs - ys;
            2'b11: arithR = xs - 16'd1;
            default: arithR = 16'h0000;
        endcase
    end

    assign r_o = u_i ? arithR : logicR;

endmodule

// File: rtl/alu_exec_unit.sv
// Execution unit: decodes NandGame instructions, runs the ALU, updates A/D/PC
// and performs *A reads/writes over a req/ack memory handshake.
module alu_exec_unit
    import alu_exec_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_exec_if.master       bus,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] reg_a,
    output logic [WIDTH-1:0] reg_d
);

    logic [1:0]       state_q,   state_d;
    logic             ready_q,   ready_d;
    logic [WIDTH-1:0] instr_q,   instr_d;
    logic [WIDTH-1:0] operand_q, operand_d;
    logic [WIDTH-1:0] addr_q,    addr_d;
    logic [WIDTH-1:0] wdata_q,   wdata_d;
    logic [WIDTH-1:0] pc_q,      pc_d;
    logic [WIDTH-1:0] a_q,       a_d;
    logic [WIDTH-1:0] d_q,       d_d;

    alu_ctrl_t        ctrl;
    logic [WIDTH-1:0] aluR;
    logic             accept;
    logic             jump;
    logic             unused_instr_bits;

    assign ctrl = '{u:   instr_q[U],
                    op1: instr_q[OP1],
                    op0: instr_q[OP0],
                    zx:  instr_q[ZX],
                    sw:  instr_q[SW]};

    assign unused_instr_bits = ^{instr_q[CI], instr_q[14:13], instr_q[11]};

    alu16_core u_core (
        .x_i   (d_q),
        .y_i   (operand_q),
        .u_i   (ctrl.u),
        .op1_i (ctrl.op1),
        .op0_i (ctrl.op0),
        .zx_i  (ctrl.zx),
        .sw_i  (ctrl.sw),
        .r_o   (aluR)
    );

    assign accept = bus.instr_valid & ready_q;

    assign jump = (instr_q[LT] &  aluR[WIDTH-1])
                | (instr_q[EQ] & (aluR == '0))
                | (instr_q[GT] & ~aluR[WIDTH-1] & (aluR != '0));

    // addr_q holds the pre-instruction A for the whole ALU instruction, so it
    // doubles as the memory address and the jump target.
    always_comb begin
        state_d   = state_q;
        instr_d   = instr_q;
        operand_d = operand_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        pc_d      = pc_q;
        a_d       = a_q;
        d_d       = d_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!bus.instr[CI]) begin
                        a_d  = {1'b0, bus.instr[WIDTH-2:0]};
                        pc_d = pc_q + WIDTH'(1);
                    end else begin
                        instr_d   = bus.instr;
                        addr_d    = a_q;
                        operand_d = a_q;
                        state_d   = bus.instr[SEL_MEM] ? RD : EXEC;
                    end
                end
            end
            RD: begin
                if (bus.mem_ack) begin
                    operand_d = bus.mem_rdata;
                    state_d   = EXEC;
                end
            end
            EXEC: begin
                if (instr_q[DST_A]) a_d = aluR;
                if (instr_q[DST_D]) d_d = aluR;
                pc_d    = jump ? addr_q : pc_q + WIDTH'(1);
                wdata_d = aluR;
                state_d = instr_q[DST_MEM] ? WR : IDLE;
            end
            WR: begin
                if (bus.mem_ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ready_q   <= 1'b0;
            instr_q   <= '0;
            operand_q <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            pc_q      <= '0;
            a_q       <= '0;
            d_q       <= '0;
        end else begin
            state_q   <= state_d;
            ready_q   <= ready_d;
            instr_q   <= instr_d;
            operand_q <= operand_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            pc_q      <= pc_d;
            a_q       <= a_d;
            d_q       <= d_d;
        end
    end

    assign bus.instr_ready = ready_q;
    assign bus.mem_req     = (state_q == RD) || (state_q == WR);
    assign bus.mem_we      = (state_q == WR);
    assign bus.mem_addr    = addr_q;
    assign bus.mem_wdata   = wdata_q;
    assign pc              = pc_q;
    assign reg_a           = a_q;
    assign reg_d           = d_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed scenarios then random
// instructions compared against an instruction-level model of A, D and PC.
module tb_alu_exec_unit;

    logic        clk;
    logic        rst_n;
    logic [15:0] pc;
    logic [15:0] reg_a;
    logic [15:0] reg_d;

    alu_exec_if bus ();

    alu_exec_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .pc    (pc),
        .reg_a (reg_a),
        .reg_d (reg_d)
    );

    int checkCount = 0;
    int errCount   = 0;

    logic [15:0] mA, mD, mPc;
    logic [15:0] lastWdata;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: observed %h expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Instruction-level ALU semantics, computed with plain integer arithmetic.
    function automatic logic [15:0] refAlu(input logic [15:0] ins, input logic [15:0] dv,
                                           input logic [15:0] yv);
        int x, y, res;
        x = int'(dv);
        y = int'(yv);
        if (ins[6]) begin
            x = int'(yv);
            y = int'(dv);
        end
        if (ins[7]) x = 0;
        case ({ins[10], ins[9], ins[8]})
            3'd0: res = x & y;
            3'd1: res = x | y;
            3'd2: res = x ^ y;
            3'd3: res = ~x;
            3'd4: res = x + y;
            3'd5: res = x + 1;
            3'd6: res = x - y;
            default: res = x - 1;
        endcase
        return res[15:0];
    endfunction

    function automatic bit refJump(input logic [15:0] ins, input logic [15:0] r);
        int sr;
        sr = int'($signed(r));
        return (ins[2] && sr < 0) || (ins[1] && sr == 0) || (ins[0] && sr > 0);
    endfunction

    task automatic applyStimulus(input logic [15:0] ins, input int ackDelay,
                                 input logic [15:0] rdVal);
        int cyc, waitCnt, expCyc;
        logic [15:0] oldA, operand, r;
        bit sawRd, sawWr, selMem, dstMem;
        cyc = 0;
        while (!bus.instr_ready && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (!bus.instr_ready) begin
            checkOutput("readyTimeout", {15'b0, bus.instr_ready}, 16'h0001);
            return;
        end
        oldA = mA;
        bus.instr_valid = 1'b1;
        bus.instr       = ins;
        bus.mem_ack     = !ins[15];
        @(posedge clk); #1;
        bus.instr_valid = 1'b0;
        bus.mem_ack     = 1'b0;
        bus.instr       = 16'($urandom);
        if (!ins[15]) begin
            mA  = {1'b0, ins[14:0]};
            mPc = mPc + 16'd1;
            checkOutput("loadReady", {15'b0, bus.instr_ready}, 16'h0001);
            checkOutput("loadRegA", reg_a, mA);
            checkOutput("loadPc", pc, mPc);
            return;
        end
        selMem  = ins[12];
        dstMem  = ins[3];
        operand = oldA;
        r       = refAlu(ins, mD, operand);
        sawRd   = 0;
        sawWr   = 0;
        cyc     = 1;
        waitCnt = 0;
        while (!bus.instr_ready && cyc < 200) begin
            if (bus.mem_req) begin
                if (waitCnt < ackDelay) begin
                    waitCnt++;
                    checkOutput("addrStable", bus.mem_addr, oldA);
                end else begin
                    waitCnt = 0;
                    checkOutput("memAddr", bus.mem_addr, oldA);
                    if (!bus.mem_we) begin
                        sawRd         = 1;
                        operand       = rdVal;
                        r             = refAlu(ins, mD, operand);
                        bus.mem_rdata = rdVal;
                    end else begin
                        sawWr     = 1;
                        lastWdata = bus.mem_wdata;
                        checkOutput("memWdata", bus.mem_wdata, r);
                    end
                    bus.mem_ack = 1'b1;
                end
            end
            @(posedge clk); #1;
            bus.mem_ack   = 1'b0;
            bus.mem_rdata = 16'($urandom);
            cyc++;
        end
        checkOutput("doneReady", {15'b0, bus.instr_ready}, 16'h0001);
        checkOutput("sawRead", {15'b0, sawRd}, {15'b0, selMem});
        checkOutput("sawWrite", {15'b0, sawWr}, {15'b0, dstMem});
        expCyc = 2 + (selMem ? 1 + ackDelay : 0) + (dstMem ? 1 + ackDelay : 0);
        checkOutput("latency", 16'(cyc), 16'(expCyc));
        if (ins[5]) mA = r;
        if (ins[4]) mD = r;
        mPc = refJump(ins, r) ? oldA : mPc + 16'd1;
        checkOutput("aluRegA", reg_a, mA);
        checkOutput("aluRegD", reg_d, mD);
        checkOutput("aluPc", pc, mPc);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "Pc"}, pc, 16'h0000);
        checkOutput({tag, "RegA"}, reg_a, 16'h0000);
        checkOutput({tag, "RegD"}, reg_d, 16'h0000);
        checkOutput({tag, "Addr"}, bus.mem_addr, 16'h0000);
        checkOutput({tag, "Wdata"}, bus.mem_wdata, 16'h0000);
        checkOutput({tag, "Req"}, {15'b0, bus.mem_req}, 16'h0000);
        checkOutput({tag, "We"}, {15'b0, bus.mem_we}, 16'h0000);
        checkOutput({tag, "Ready"}, {15'b0, bus.instr_ready}, 16'h0000);
    endtask

    initial begin
        int cnt;
        logic [15:0] ins;
        rst_n           = 1'b0;
        bus.instr_valid = 1'b0;
        bus.instr       = 16'h0000;
        bus.mem_rdata   = 16'h0000;
        bus.mem_ack     = 1'b0;
        mA = 16'h0; mD = 16'h0; mPc = 16'h0;
        lastWdata = 16'h0;

        repeat (3) @(posedge clk);
        #1;
        checkResetState("reset");
        rst_n = 1'b1;
        #1;
        checkOutput("readyBeforeEdge", {15'b0, bus.instr_ready}, 16'h0000);
        @(posedge clk); #1;
        checkOutput("readyAfterEdge", {15'b0, bus.instr_ready}, 16'h0001);

        applyStimulus(16'h0005, 0, 16'h0);
        checkOutput("firstLoadA", reg_a, 16'h0005);
        applyStimulus(16'h8410, 0, 16'h0);
        checkOutput("addDirD", reg_d, 16'h0005);
        checkOutput("addDirPc", pc, 16'h0002);

        applyStimulus(16'h0003, 0, 16'h0);
        applyStimulus(16'h8490, 0, 16'h0);
        applyStimulus(16'h0010, 0, 16'h0);
        applyStimulus(16'h9608, 3, 16'h0007);
        checkOutput("subWrData", lastWdata, 16'hFFFC);

        applyStimulus(16'h0000, 0, 16'h0);
        applyStimulus(16'h8790, 0, 16'h0);
        applyStimulus(16'h0040, 0, 16'h0);
        applyStimulus(16'h81E4, 0, 16'h0);
        checkOutput("ltJumpPc", pc, 16'h0040);
        checkOutput("ltJumpA", reg_a, 16'hFFFF);
        applyStimulus(16'h0040, 1, 16'h0);
        applyStimulus(16'h81E1, 0, 16'h0);
        checkOutput("gtNoJumpPc", pc, 16'h0042);

        applyStimulus(16'h0020, 0, 16'h0);
        applyStimulus(16'h8512, 0, 16'h0);
        checkOutput("wrapD", reg_d, 16'h0000);
        checkOutput("wrapEqPc", pc, 16'h0020);

        for (int i = 0; i < 300; i++) begin
            ins = 16'($urandom);
            applyStimulus(ins, int'($urandom_range(0, 4)), 16'($urandom));
        end

        // Reset while a read is waiting for its ack.
        applyStimulus(16'h0033, 0, 16'h0);
        cnt = 0;
        bus.instr_valid = 1'b1;
        bus.instr       = 16'h9410;
        @(posedge clk); #1;
        bus.instr_valid = 1'b0;
        checkOutput("rdReqHigh", {15'b0, bus.mem_req}, 16'h0001);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkResetState("midRd");
        @(posedge clk); #1;
        rst_n = 1'b1;
        mA = 16'h0; mD = 16'h0; mPc = 16'h0;
        #1;
        checkOutput("midRdReadyLow", {15'b0, bus.instr_ready}, 16'h0000);
        @(posedge clk); #1;
        checkOutput("midRdReadyHigh", {15'b0, bus.instr_ready}, 16'h0001);
        applyStimulus(16'h0123, 0, 16'h0);
        applyStimulus(16'h9C18, 2, 16'h1111);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, errCount);
        $finish;
    end

endmodule
